// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the CPU/DMA memory arbiter
package arb_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        CPU_OWN,
        STALL,
        DMA_OWN
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } bus_owner_t;

    // Only DMA_OWN hands the memory port to the DMA side; STALL still muxes the CPU.
    function automatic bus_owner_t owner_of(input arb_state_t s);
        return (s == DMA_OWN) ? OWN_DMA : OWN_CPU;
    endfunction

endpackage

// File: rtl/arb_timer.sv
// rtl/arb_timer.sv - loadable 8-bit counter: clear, load, count up, or count down to zero
module arb_timer
    import arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Down-counting saturates at zero so an idle gap timer parks there.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the memory port between the 6502 core and one DMA requester
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int MIN_GAP   = 2
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read_en,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_read_en,
    output logic        dma_gnt,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read_en,
    input  logic [7:0]  mem_rdata
);

    if ((MAX_BURST < 1) || (MAX_BURST > 255) || (MIN_GAP < 0) || (MIN_GAP > 255)) begin : g_param_check
        $error("mem_arbiter: MAX_BURST must be 1..255 and MIN_GAP 0..255");
    end

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(MIN_GAP);

    arb_state_t       state_q;
    arb_state_t       state_d;
    bus_owner_t       owner;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic             in_cpu;
    logic             in_dma;
    logic             dma_exit;

    assign in_cpu   = (state_q == CPU_OWN);
    assign in_dma   = (state_q == DMA_OWN);
    // Dropped request and burst cap can coincide; either one gives a single exit.
    assign dma_exit = in_dma && (!dma_req || (burst_cnt == BURST_LAST));

    // Burst counter sits at zero outside DMA_OWN, so every grant starts from zero.
    arb_timer u_burst_timer (
        .clk      (ph1),
        .rst_n    (reset),
        .clr      (!in_dma),
        .load     (1'b0),
        .load_val ('0),
        .inc      (in_dma),
        .dec      (1'b0),
        .cnt      (burst_cnt)
    );

    arb_timer u_gap_timer (
        .clk      (ph1),
        .rst_n    (reset),
        .clr      (1'b0),
        .load     (dma_exit),
        .load_val (GAP_LOAD),
        .inc      (1'b0),
        .dec      (in_cpu),
        .cnt      (gap_cnt)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CPU_OWN: begin
                if (dma_req && (gap_cnt == '0)) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                // A 6502 write ignores RDY, so wait for a read before taking the bus.
                if (!dma_req) begin
                    state_d = CPU_OWN;
                end else if (cpu_read_en) begin
                    state_d = DMA_OWN;
                end
            end
            DMA_OWN: begin
                if (dma_exit) begin
                    state_d = CPU_OWN;
                end
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q <= CPU_OWN;
        end else begin
            state_q <= state_d;
        end
    end

    assign owner   = owner_of(state_q);
    assign cpu_rdy = in_cpu;
    assign dma_gnt = in_dma;

    // A DMA cycle whose request has gone away is turned into a harmless read.
    always_comb begin
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;
        mem_read_en = cpu_read_en;
        if (owner == OWN_DMA) begin
            mem_addr    = dma_addr;
            mem_wdata   = dma_wdata;
            mem_read_en = dma_req ? dma_read_en : 1'b1;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

endmodule
